alu_operand_sequencer: RTL

Front-end stage that feeds the ALU/display top level: it turns noisy board pushbuttons and slide switches into stable, registered ALU operands and an operation code. Operands A and B and the signedness flag are captured from SW at button presses, the op code is stepped by a button, and a VALID level tells the ALU stage its inputs are complete. This stage replaces the direct SW/KEY wiring into the ALU.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_operand_sequencer_if.sv | 26 ++
 rtl/key_debouncer.sv | 47 ++++
 rtl/alu_operand_sequencer.sv | 92 +++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and field constants for the ALU operand sequencer front-end.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    GOT_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int OP_W   = 3;
  localparam int OPND_W = 8;
  localparam int SW_W   = 17;

  localparam int SW_A_LSB = 0;
  localparam int SW_A_MSB = 7;
  localparam int SW_B_LSB = 8;
  localparam int SW_B_MSB = 15;
  localparam int SW_UNSIG = 16;

  localparam int KEY_ENTER   = 1;
  localparam int KEY_OP_NEXT = 2;
  localparam int KEY_CLEAR   = 3;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle: raw switches/keys in, latched ALU operands and status out.
interface alu_operand_sequencer_if
  import alu_seq_pkg::*;
();

  logic [SW_W-1:0]   SW;
  logic [3:1]        KEY;
  logic [OPND_W-1:0] A;
  logic [OPND_W-1:0] B;
  logic              UNSIG;
  logic [OP_W:1]     OP;
  logic              VALID;
  logic              START;
  logic [1:0]        STATE;

  modport master (
    output SW, KEY,
    input  A, B, UNSIG, OP, VALID, START, STATE
  );

  modport slave (
    input  SW, KEY,
    output A, B, UNSIG, OP, VALID, START, STATE
  );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low pushbutton; emits a one-cycle press pulse.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_press
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // The press pulse is raised on the same edge the level flips to 0, so the
  // consumer sees it one cycle after the last stable sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures ALU operands and op code from switches under debounced key control.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  alu_operand_sequencer_if.slave  bus
);

  logic w_enterEv;
  logic w_opNextEv;
  logic w_clearEv;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_key(bus.KEY[KEY_ENTER]), .o_press(w_enterEv)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_opNext (
    .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_key(bus.KEY[KEY_OP_NEXT]), .o_press(w_opNextEv)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .i_clk(CLOCK_50), .i_rst_n(RESET_N), .i_key(bus.KEY[KEY_CLEAR]), .o_press(w_clearEv)
  );

  state_t            r_state;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic              r_unsig;
  logic [OP_W:1]     r_op;
  logic              r_valid;
  logic              r_start;

  // CLEAR wins over everything; ENTER and OP_NEXT in the same cycle both apply.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_unsig <= 1'b0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_clearEv) begin
        r_state <= IDLE;
        r_a     <= '0;
        r_b     <= '0;
        r_unsig <= 1'b0;
        r_op    <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_opNextEv) begin
          r_op <= r_op + OP_W'(1);
        end
        if (w_enterEv) begin
          case (r_state)
            IDLE, DONE: begin
              r_a     <= bus.SW[SW_A_MSB:SW_A_LSB];
              r_state <= GOT_A;
              r_valid <= 1'b0;
            end
            GOT_A: begin
              r_b     <= bus.SW[SW_B_MSB:SW_B_LSB];
              r_unsig <= bus.SW[SW_UNSIG];
              r_state <= GOT_B;
            end
            GOT_B: begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_start <= 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.A     = r_a;
  assign bus.B     = r_b;
  assign bus.UNSIG = r_unsig;
  assign bus.OP    = r_op;
  assign bus.VALID = r_valid;
  assign bus.START = r_start;
  assign bus.STATE = r_state;

endmodule
